// File: rtl/design_03_pkg.sv
// design_03_pkg
//  Shared constants and types for the design_03 issuer slice.
//  - WIDTH_DEFAULT : operand/result width of the downstream methods.
//  - CNT_W         : width of the issued/done event counters.
//  - op_t          : one host command {a,b,c} at the default width.
package design_03_pkg;

  localparam int WIDTH_DEFAULT = 7;
  localparam int CNT_W         = 16;

  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] a;
    logic [WIDTH_DEFAULT-1:0] b;
    logic [WIDTH_DEFAULT-1:0] c;
  } op_t;

endpackage

// File: rtl/design_03_sync_fifo.sv
// design_03_sync_fifo
//  Single-clock FIFO with registered storage and occupancy.
//  A push while full is dropped even if a pop happens in the same cycle
//  (no bypass), so fullness alone decides whether a write is taken.
//  Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write request and data (ignored while full)
//   pop         : read request (ignored while empty)
//   dout        : head entry, read from the storage registers
//   full, empty : occupancy flags
module design_03_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  T              mem_r [DEPTH];
  logic          push_ok_s;
  logic          pop_ok_s;

  // Pointer advance with explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/design_03_issuer.sv
// design_03_issuer
//  Host-side command issuer for mkDesign_03. Host triples {a,b,c} are buffered
//  in the op FIFO, issued to the downstream start method (a,b), and c is parked
//  in the c queue until the result method can be called. Results come back to
//  the host in start order through a single output register.
//  Ports:
//   CLK, RST                     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a,b,c   : host command stream
//   start_a/start_b/RDY_start/EN_start : downstream start method
//   result_c/result/RDY_result/EN_result : downstream result method
//   out_valid/out_ready/out_data : host result stream
//   issued_cnt, done_cnt         : wrapping start / delivery counters
module design_03_issuer
  import design_03_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic [WIDTH-1:0] start_a,
  output logic [WIDTH-1:0] start_b,
  input  logic             RDY_start,
  output logic             EN_start,
  output logic [WIDTH-1:0] result_c,
  input  logic [WIDTH-1:0] result,
  input  logic             RDY_result,
  output logic             EN_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt
);

  // Same layout as op_t, but sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } op_w_t;

  op_w_t            op_in_s;
  op_w_t            op_head_s;
  logic             op_full_s;
  logic             op_empty_s;
  logic             cq_full_s;
  logic             cq_empty_s;
  logic             push_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CNT_W-1:0] issued_cnt_r;
  logic [CNT_W-1:0] done_cnt_r;

  assign op_in_s = '{a: in_a, b: in_b, c: in_c};

  // in_ready is forced low while reset is held so no command slips in.
  assign in_ready = ~op_full_s & ~RST;
  assign push_s   = in_valid & in_ready;

  // A start is only allowed when the c queue has room, which bounds the
  // number of started-but-uncollected ops to MAX_OUT.
  assign EN_start  = ~op_empty_s & RDY_start & ~cq_full_s;
  assign EN_result = ~cq_empty_s & RDY_result & (~out_valid_r | out_ready);

  assign start_a   = op_head_s.a;
  assign start_b   = op_head_s.b;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign issued_cnt = issued_cnt_r;
  assign done_cnt   = done_cnt_r;

  design_03_sync_fifo #(.T(op_w_t), .DEPTH(DEPTH)) u_op_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .din   (op_in_s),
    .pop   (EN_start),
    .dout  (op_head_s),
    .full  (op_full_s),
    .empty (op_empty_s)
  );

  design_03_sync_fifo #(.T(logic [WIDTH-1:0]), .DEPTH(MAX_OUT)) u_c_queue (
    .clk   (CLK),
    .rst   (RST),
    .push  (EN_start),
    .din   (op_head_s.c),
    .pop   (EN_result),
    .dout  (result_c),
    .full  (cq_full_s),
    .empty (cq_empty_s)
  );

  // Host output register: a new result may replace one being handed off.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else if (EN_result) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Event counters; both wrap silently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issued_cnt_r <= {CNT_W{1'b0}};
      done_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (EN_start) begin
        issued_cnt_r <= issued_cnt_r + CNT_W'(1);
      end
      if (out_valid_r & out_ready) begin
        done_cnt_r <= done_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_design_03_issuer.sv
// tb_design_03_issuer
//  Directed bench for design_03_issuer. The bench plays the downstream design:
//  result = result_c + 10, so each delivered value identifies its op by c.
//  Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_design_03_issuer;
  import design_03_pkg::*;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_a;
  logic [6:0]  in_b;
  logic [6:0]  in_c;
  logic [6:0]  start_a;
  logic [6:0]  start_b;
  logic        RDY_start;
  logic        EN_start;
  logic [6:0]  result_c;
  logic [6:0]  result;
  logic        RDY_result;
  logic        EN_result;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic [15:0] issued_cnt;
  logic [15:0] done_cnt;

  int n_cmp;
  int n_bad;
  int n_start;
  int n_res;
  logic [6:0] got_q[$];

  design_03_issuer dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .start_a(start_a), .start_b(start_b),
    .RDY_start(RDY_start), .EN_start(EN_start),
    .result_c(result_c), .result(result),
    .RDY_result(RDY_result), .EN_result(EN_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt)
  );

  assign result = result_c + 7'd10;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: count method fires and record host handoffs (pre-edge values).
  always @(posedge CLK) begin
    if (EN_start) n_start++;
    if (EN_result) n_res++;
    if (out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic push_op(input op_t op);
    @(negedge CLK);
    in_valid = 1'b1; in_a = op.a; in_b = op.b; in_c = op.c;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL push_ready c=%0d: in_ready=%b want 1", op.c, in_ready);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; in_valid = 1'b1; in_a = 7'd1; in_b = 7'd2; in_c = 7'd3;
    RDY_start = 1'b1; RDY_result = 1'b1; out_ready = 1'b1;
    @(negedge CLK); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (EN_start !== 1'b0) begin n_bad++; $display("FAIL rst_en_start: got %b want 0", EN_start); end
    n_cmp++; if (EN_result !== 1'b0) begin n_bad++; $display("FAIL rst_en_result: got %b want 0", EN_result); end
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 7'd0) begin
      n_bad++; $display("FAIL rst_out: valid=%b data=%0d want 0/0", out_valid, out_data); end
    n_cmp++; if (issued_cnt !== 16'd0 || done_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rst_cnt: issued=%0d done=%0d want 0/0", issued_cnt, done_cnt); end
    @(negedge CLK);
    RST = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_single;
    push_op('{a: 7'd3, b: 7'd5, c: 7'd1});
    @(negedge CLK); in_valid = 1'b0; #1;
    n_cmp++; if (EN_start !== 1'b1 || start_a !== 7'd3 || start_b !== 7'd5 || EN_result !== 1'b0) begin
      n_bad++; $display("FAIL single_start: en=%b a=%0d b=%0d enr=%b want 1/3/5/0", EN_start, start_a, start_b, EN_result); end
    @(negedge CLK); #1;
    n_cmp++; if (EN_result !== 1'b1 || result_c !== 7'd1 || EN_start !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_result: enr=%b c=%0d en=%b ov=%b want 1/1/0/0", EN_result, result_c, EN_start, out_valid); end
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 7'd11 || issued_cnt !== 16'd1) begin
      n_bad++; $display("FAIL single_out: ov=%b data=%0d issued=%0d want 1/11/1", out_valid, out_data, issued_cnt); end
    @(negedge CLK); #1;
    n_cmp++; if (done_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_done: done=%0d ov=%b want 1/0", done_cnt, out_valid); end
  endtask

  task automatic test_backpressure;
    int qb;
    logic rdy;
    qb = got_q.size();
    RDY_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_a = 7'(i); in_b = 7'(i + 1); in_c = 7'(20 + i);
      #1;
      rdy = (i < 4) ? 1'b1 : 1'b0;
      n_cmp++; if (in_ready !== rdy) begin
        n_bad++; $display("FAIL bp_fill%0d: in_ready=%b want %b", i, in_ready, rdy); end
    end
    @(negedge CLK); RDY_start = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0 || EN_start !== 1'b1) begin
      n_bad++; $display("FAIL bp_nobypass: in_ready=%b en=%b want 0/1", in_ready, EN_start); end
    @(negedge CLK); #1;
    n_cmp++; if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_accept5: in_ready=%b want 1", in_ready); end
    @(negedge CLK); in_valid = 1'b0;
    for (int k = 0; k < 40 && got_q.size() < qb + 5; k++) @(negedge CLK);
    #1;
    n_cmp++; if (got_q.size() !== qb + 5) begin
      n_bad++; $display("FAIL bp_count: got %0d results want 5", got_q.size() - qb); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (got_q[qb + i] !== 7'(30 + i)) begin
          n_bad++; $display("FAIL bp_order%0d: got %0d want %0d", i, got_q[qb + i], 30 + i); end
      end
    end
    n_cmp++; if (issued_cnt !== 16'd6 || done_cnt !== 16'd6) begin
      n_bad++; $display("FAIL bp_cnt: issued=%0d done=%0d want 6/6", issued_cnt, done_cnt); end
  endtask

  task automatic test_outstanding;
    int qb;
    int sb;
    qb = got_q.size(); sb = n_start;
    RDY_result = 1'b0;
    for (int i = 0; i < 6; i++) push_op('{a: 7'(i), b: 7'(i), c: 7'(40 + i)});
    idle(6);
    n_cmp++; if (n_start - sb !== 4 || EN_start !== 1'b0) begin
      n_bad++; $display("FAIL cap_starts: starts=%0d en=%b want 4/0", n_start - sb, EN_start); end
    RDY_result = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < qb + 6; k++) @(negedge CLK);
    #1;
    n_cmp++; if (got_q.size() !== qb + 6 || n_start - sb !== 6) begin
      n_bad++; $display("FAIL cap_drain: results=%0d starts=%0d want 6/6", got_q.size() - qb, n_start - sb); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (got_q[qb + i] !== 7'(50 + i)) begin
          n_bad++; $display("FAIL cap_order%0d: got %0d want %0d", i, got_q[qb + i], 50 + i); end
      end
    end
  endtask

  task automatic test_host_stall;
    int qb;
    int rb;
    qb = got_q.size(); rb = n_res;
    out_ready = 1'b0;
    push_op('{a: 7'd1, b: 7'd1, c: 7'd60});
    push_op('{a: 7'd2, b: 7'd2, c: 7'd61});
    idle(8);
    n_cmp++; if (n_res - rb !== 1 || out_valid !== 1'b1 || out_data !== 7'd70 || got_q.size() !== qb) begin
      n_bad++; $display("FAIL stall_hold: fires=%0d ov=%b data=%0d handoffs=%0d want 1/1/70/0",
                        n_res - rb, out_valid, out_data, got_q.size() - qb); end
    @(negedge CLK); out_ready = 1'b1; #1;
    n_cmp++; if (EN_result !== 1'b1) begin
      n_bad++; $display("FAIL stall_refire: EN_result=%b want 1", EN_result); end
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 7'd71 || got_q.size() !== qb + 1) begin
      n_bad++; $display("FAIL stall_second: ov=%b data=%0d handoffs=%0d want 1/71/1", out_valid, out_data, got_q.size() - qb); end
    idle(2);
    n_cmp++; if (got_q.size() !== qb + 2 || got_q[qb] !== 7'd70 || got_q[qb + 1] !== 7'd71 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_order: n=%0d ov=%b want 70,71 delivered", got_q.size() - qb, out_valid); end
  endtask

  task automatic test_reset_mid;
    int qb;
    RDY_result = 1'b0;
    for (int i = 0; i < 3; i++) push_op('{a: 7'(i), b: 7'(i), c: 7'(i + 1)});
    idle(1);
    @(negedge CLK); RST = 1'b1; in_valid = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0 || EN_start !== 1'b0 || EN_result !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_en: ready=%b en=%b enr=%b want 0/0/0", in_ready, EN_start, EN_result); end
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 7'd0 || issued_cnt !== 16'd0 || done_cnt !== 16'd0) begin
      n_bad++; $display("FAIL mid_rst_state: ov=%b data=%0d issued=%0d done=%0d want all 0",
                        out_valid, out_data, issued_cnt, done_cnt); end
    @(negedge CLK); RST = 1'b0; in_valid = 1'b0; RDY_result = 1'b1;
    qb = got_q.size();
    push_op('{a: 7'd9, b: 7'd9, c: 7'd7});
    idle(6);
    n_cmp++; if (got_q.size() !== qb + 1 || issued_cnt !== 16'd1 || done_cnt !== 16'd1) begin
      n_bad++; $display("FAIL mid_after: results=%0d issued=%0d done=%0d want 1/1/1", got_q.size() - qb, issued_cnt, done_cnt); end
    else begin
      n_cmp++; if (got_q[qb] !== 7'd17) begin
        n_bad++; $display("FAIL mid_data: got %0d want 17", got_q[qb]); end
    end
  endtask

  task automatic test_wrap;
    int p;
    @(negedge CLK); RST = 1'b1; in_valid = 1'b0;
    @(negedge CLK); RST = 1'b0;
    p = 0;
    for (int k = 0; k < 70000 && p < 65535; k++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_a = 7'(k); in_b = 7'(k); in_c = 7'(k);
      #1;
      if (in_ready) p++;
    end
    idle(6);
    n_cmp++; if (issued_cnt !== 16'hFFFF || done_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL wrap_pre: issued=%h done=%h want ffff/ffff", issued_cnt, done_cnt); end
    push_op('{a: 7'd0, b: 7'd0, c: 7'd0});
    idle(6);
    n_cmp++; if (issued_cnt !== 16'h0000 || done_cnt !== 16'h0000) begin
      n_bad++; $display("FAIL wrap_post: issued=%h done=%h want 0000/0000", issued_cnt, done_cnt); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_start = 0; n_res = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_outstanding();
    test_host_stall();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
